// File: rtl/pila_pkg.sv
// Shared definitions for the return-address stack, the PC and the control unit.
// Jump-control codes and default sizes live here so all three agree on encoding.
package pila_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic [1:0] SALTO_SEQ  = 2'b00;
  localparam logic [1:0] SALTO_JMP  = 2'b01;
  localparam logic [1:0] SALTO_CALL = 2'b10;
  localparam logic [1:0] SALTO_RET  = 2'b11;

endpackage

// File: rtl/pila_mem.sv
// DEPTH x ADDR_W register file for the return-address stack.
// One synchronous write port, one asynchronous read port, no reset on storage.
module pila_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the count in the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/pila_retorno.sv
// Return-address stack beside the PC: pushes PC+1 on call, supplies top of stack on return.
// Build option PILA_CIRCULAR_EN: push-when-full overwrites the oldest entry (ring behaviour).
module pila_retorno
  import pila_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Control_PC,
  input  logic [1:0]        i_Control_Saltos,
  input  logic [ADDR_W-1:0] i_Direccion_PC,
  input  logic              i_Limpiar_Errores,
  output logic [ADDR_W-1:0] o_Direccion_Retorno,
  output logic              o_Retorno_Valido,
  output logic              o_Vacia,
  output logic              o_Llena,
  output logic [CNT_W-1:0]  o_Profundidad,
  output logic              o_Desborde,
  output logic              o_Subdesborde
);

  // ptr_q is the next write slot and wraps modulo DEPTH, so in the ring build the
  // oldest entry (base = ptr - count) is exactly the slot a full push overwrites.
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              desb_q, desb_d;
  logic              subd_q, subd_d;

  logic              op_push, op_pop;
  logic              vacia, llena;
  logic              mem_we;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top_data;
  logic [ADDR_W-1:0] push_data;

  assign op_push   = !i_Control_PC && (i_Control_Saltos == SALTO_CALL);
  assign op_pop    = !i_Control_PC && (i_Control_Saltos == SALTO_RET);
  assign vacia     = (cnt_q == '0);
  assign llena     = (cnt_q == CNT_W'(DEPTH));
  assign top_idx   = ptr_q - IDX_W'(1);
  assign push_data = i_Direccion_PC + ADDR_W'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    mem_we = 1'b0;
    desb_d = i_Limpiar_Errores ? 1'b0 : desb_q;
    subd_d = i_Limpiar_Errores ? 1'b0 : subd_q;

    if (op_push) begin
      if (!llena) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + IDX_W'(1);
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        desb_d = 1'b1;
`ifdef PILA_CIRCULAR_EN
        mem_we = 1'b1;
        ptr_d  = ptr_q + IDX_W'(1);
`endif
      end
    end else if (op_pop) begin
      if (!vacia) begin
        ptr_d = ptr_q - IDX_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        subd_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      desb_q <= 1'b0;
      subd_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      desb_q <= desb_d;
      subd_q <= subd_d;
    end
  end

  pila_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i     (i_Clk),
    .we_i      (mem_we),
    .wr_idx_i  (ptr_q),
    .wr_data_i (push_data),
    .rd_idx_i  (top_idx),
    .rd_data_o (top_data)
  );

  assign o_Direccion_Retorno = vacia ? '0 : top_data;
  assign o_Retorno_Valido    = op_pop && !vacia;
  assign o_Vacia             = vacia;
  assign o_Llena             = llena;
  assign o_Profundidad       = cnt_q;
  assign o_Desborde          = desb_q;
  assign o_Subdesborde       = subd_q;

endmodule

// File: tb/tb_pila_retorno.sv
// Directed bench for pila_retorno: a reference LIFO model feeds a scoreboard of expected
// return addresses, checked in the same cycle the return is presented.
module tb_pila_retorno;
  import pila_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ctrl_pc;
  logic [1:0]        saltos;
  logic [ADDR_W-1:0] dir_pc;
  logic              limpiar;
  logic [ADDR_W-1:0] dir_ret;
  logic              ret_valido;
  logic              vacia;
  logic              llena;
  logic [CNT_W-1:0]  prof;
  logic              desborde;
  logic              subdesborde;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] model_stk[$];
  logic              m_desb;
  logic              m_subd;
  logic [ADDR_W:0]   exp_q[$];

  pila_retorno #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_Clk               (clk),
    .i_Rst_n             (rst_n),
    .i_Control_PC        (ctrl_pc),
    .i_Control_Saltos    (saltos),
    .i_Direccion_PC      (dir_pc),
    .i_Limpiar_Errores   (limpiar),
    .o_Direccion_Retorno (dir_ret),
    .o_Retorno_Valido    (ret_valido),
    .o_Vacia             (vacia),
    .o_Llena             (llena),
    .o_Profundidad       (prof),
    .o_Desborde          (desborde),
    .o_Subdesborde       (subdesborde)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_flags();
    if (limpiar) begin
      m_desb = 1'b0;
      m_subd = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [ADDR_W-1:0] top;
    top = (model_stk.size() == 0) ? '0 : model_stk[$];
    check({tag, ".prof"},  32'(prof),        32'(model_stk.size()));
    check({tag, ".vacia"}, 32'(vacia),       32'(model_stk.size() == 0));
    check({tag, ".llena"}, 32'(llena),       32'(model_stk.size() == DEPTH));
    check({tag, ".desb"},  32'(desborde),    32'(m_desb));
    check({tag, ".subd"},  32'(subdesborde), 32'(m_subd));
    check({tag, ".top"},   32'(dir_ret),     32'(top));
  endtask

  task automatic do_call(input logic [ADDR_W-1:0] pc);
    saltos = SALTO_CALL;
    dir_pc = pc;
    model_clear_flags();
    if (model_stk.size() < DEPTH) begin
      model_stk.push_back(pc + 8'd1);
    end else begin
      m_desb = 1'b1;
`ifdef PILA_CIRCULAR_EN
      void'(model_stk.pop_front());
      model_stk.push_back(pc + 8'd1);
`endif
    end
    tick();
    saltos = SALTO_SEQ;
  endtask

  task automatic do_ret(input string tag);
    logic [ADDR_W:0] e;
    saltos = SALTO_RET;
    model_clear_flags();
    if (model_stk.size() > 0) exp_q.push_back({1'b1, model_stk[$]});
    else                      exp_q.push_back({1'b0, 8'h00});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".addr"},  32'(dir_ret),    32'(e[ADDR_W-1:0]));
    check({tag, ".valid"}, 32'(ret_valido), 32'(e[ADDR_W]));
    if (model_stk.size() > 0) void'(model_stk.pop_back());
    else                      m_subd = 1'b1;
    tick();
    saltos = SALTO_SEQ;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_stk.delete();
    m_desb = 1'b0;
    m_subd = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    ctrl_pc = 1'b0;
    saltos  = SALTO_SEQ;
    dir_pc  = '0;
    limpiar = 1'b0;
    m_desb  = 1'b0;
    m_subd  = 1'b0;

    // 1: reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_state("reset");

    // 2: two calls then two returns
    do_call(8'h10);
    check_state("call10");
    do_call(8'h20);
    check_state("call20");
    do_ret("ret_a");
    do_ret("ret_b");
    check_state("after_rets");

    // 3: address wrap on push
    do_call(8'hFF);
    check_state("call_ff");
    do_ret("ret_wrap");
    check_state("after_wrap");

    // 4/5: nine calls into an eight-entry stack
    for (int i = 1; i <= 9; i++) do_call(8'(i));
    check_state("full");
    for (int i = 0; i < DEPTH; i++) do_ret("ret_full");
    check_state("drained");

    // 6: underflow, then clear, then error-wins-over-clear
    do_ret("ret_empty");
    check_state("underflow");
    limpiar = 1'b1;
    model_clear_flags();
    tick();
    limpiar = 1'b0;
    check_state("cleared");
    limpiar = 1'b1;
    do_ret("ret_empty_clr");
    limpiar = 1'b0;
    check_state("err_wins");

    // free-run mode ignores a call code
    limpiar = 1'b1;
    model_clear_flags();
    tick();
    limpiar = 1'b0;
    ctrl_pc = 1'b1;
    saltos  = SALTO_CALL;
    dir_pc  = 8'h40;
    tick();
    ctrl_pc = 1'b0;
    saltos  = SALTO_SEQ;
    check_state("free_run");

    // reset asserted mid-sequence with a call pending across the edge
    do_call(8'h30);
    do_call(8'h31);
    saltos = SALTO_CALL;
    dir_pc = 8'h32;
    do_reset();
    check("midreset.prof_async", 32'(prof), 32'd0);
    tick();
    saltos = SALTO_SEQ;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_state("after_midreset");
    do_call(8'h50);
    do_ret("ret_post_reset");
    check_state("final");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
